// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side drain stage.
package fifo_pkg;

  // FIFO read latency from fifo_rd_en to valid data: registered enable
  // followed by registered data output.
  localparam int unsigned RD_PIPE_LAT = 2;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Circular first-word-fall-through buffer absorbing the FIFO read pipeline.
// The head entry is always presented on head_data; level counts occupancy.
module fifo_rd_skid_buf
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BUF_DEPTH  = 4
) (
  input  logic                                 rd_clk,
  input  logic                                 rst_n,
  input  logic                                 push,
  input  logic [DATA_WIDTH-1:0]                push_data,
  input  logic                                 pop,
  output logic [level_width(BUF_DEPTH)-1:0]    level,
  output logic [DATA_WIDTH-1:0]                head_data
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  do_pop;

  // A pop against an empty buffer is ignored so level can never underflow.
  assign do_pop    = pop & (level != '0);
  assign head_data = mem[rd_ptr];

  // Storage, pointers (wrapping naturally at the power-of-two depth) and level.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side drain stage: turns the FIFO pulse-read port into a valid/ready
// stream. Shadows the FIFO read pipeline so every popped word is captured
// exactly once, and throttles requests so the local buffer cannot overflow.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BUF_DEPTH  = 4
) (
  input  logic                              rd_clk,
  input  logic                              rst_n,
  input  logic                              fifo_empty,
  input  logic [DATA_WIDTH-1:0]             fifo_data,
  output logic                              fifo_rd_en,
  output logic                              m_valid,
  input  logic                              m_ready,
  output logic [DATA_WIDTH-1:0]             m_data,
  output logic [level_width(BUF_DEPTH)-1:0] buf_level
);

  localparam int unsigned LVL_W = level_width(BUF_DEPTH);
  // Room for level plus every in-flight stage (rd_en + RD_PIPE_LAT) plus one.
  localparam int unsigned SUM_W = LVL_W + $clog2(RD_PIPE_LAT + 2);

  logic             s1;
  logic             s2;
  logic             fire;
  logic             pop;
  logic             issue;
  logic [SUM_W-1:0] committed;

  // s1 mirrors the FIFO's registered enable; the FIFO pops only if it is
  // non-empty in that same cycle, so fire tracks its pop exactly.
  assign fire = s1 & ~fifo_empty;
  assign pop  = m_valid & m_ready;

  // Issue only if the buffer can hold this request on top of everything
  // already buffered or in flight, accounting for this cycle's push/pop.
  always_comb begin
    committed = SUM_W'(buf_level) + SUM_W'(fifo_rd_en) + SUM_W'(s1)
              + SUM_W'(s2) + SUM_W'(1'b1) - SUM_W'(pop);
    issue     = ~fifo_empty & (committed <= SUM_W'(BUF_DEPTH));
  end

  // Registered read request and the two-stage shadow of the FIFO read pipe.
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_rd_en <= 1'b0;
      s1         <= 1'b0;
      s2         <= 1'b0;
    end else begin
      fifo_rd_en <= issue;
      s1         <= fifo_rd_en;
      s2         <= fire;
    end
  end

  fifo_rd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_skid_buf (
    .rd_clk    (rd_clk),
    .rst_n     (rst_n),
    .push      (s2),
    .push_data (fifo_data),
    .pop       (pop),
    .level     (buf_level),
    .head_data (m_data)
  );

  assign m_valid = (buf_level != '0);

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a behavioural FIFO read-side model.
module tb_fifo_rd_stream;

  logic       rd_clk;
  logic       rst_n;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd_en;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic [2:0] buf_level;

  fifo_rd_stream #(
    .DATA_WIDTH (8),
    .BUF_DEPTH  (4)
  ) dut (
    .rd_clk     (rd_clk),
    .rst_n      (rst_n),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd_en (fifo_rd_en),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .buf_level  (buf_level)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  // FIFO read side: registered enable, pop when enable is high and the FIFO
  // is non-empty, registered data output holding between reads.
  logic       wr_req;
  logic [7:0] wr_data;
  logic       en_q;
  logic [7:0] fq[$];

  always @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete();
      en_q       <= 1'b0;
      fifo_data  <= 8'h00;
      fifo_empty <= 1'b1;
    end else begin
      if (en_q && !fifo_empty) fifo_data <= fq.pop_front();
      if (wr_req) fq.push_back(wr_data);
      en_q       <= fifo_rd_en;
      fifo_empty <= (fq.size() == 0);
    end
  end

  int         checks;
  int         failures;
  int         cyc;
  int         n_acc;
  int         first_acc;
  int         last_acc;
  int         first_valid;
  int         empty_fall;
  int         rden_cnt;
  int         max_level;
  logic       stall_prev;
  logic [7:0] prev_data;
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic begin_test();
    n_acc       = 0;
    first_acc   = -1;
    last_acc    = -1;
    first_valid = -1;
    empty_fall  = -1;
    rden_cnt    = 0;
    max_level   = 0;
  endtask

  // One clock: observe at the falling edge, then drive inputs for the next
  // rising edge. The accept decision uses the m_ready being driven now.
  task automatic cycle(input logic rdy, input logic wr, input logic [7:0] d);
    logic [7:0] e;
    @(negedge rd_clk);
    cyc++;
    chk("level_bound", 32'(buf_level <= 3'd4), 32'd1);
    if (stall_prev) begin
      chk("stall_valid", 32'(m_valid), 32'd1);
      chk("stall_data", 32'(m_data), 32'(prev_data));
    end
    if (fifo_rd_en) rden_cnt++;
    if (!fifo_empty && empty_fall < 0) empty_fall = cyc;
    if (m_valid && first_valid < 0) first_valid = cyc;
    if (int'(buf_level) > max_level) max_level = int'(buf_level);
    m_ready = rdy;
    if (m_valid && rdy) begin
      chk("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("data", 32'(m_data), 32'(e));
      end
      n_acc++;
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
    end
    stall_prev = m_valid && !rdy;
    prev_data  = m_data;
    wr_req  = wr;
    wr_data = d;
    if (wr) exp_q.push_back(d);
  endtask

  initial begin
    int wr_cnt;
    checks     = 0;
    failures   = 0;
    cyc        = 0;
    stall_prev = 1'b0;
    prev_data  = 8'h00;
    rst_n      = 1'b0;
    m_ready    = 1'b0;
    wr_req     = 1'b0;
    wr_data    = 8'h00;
    begin_test();

    // Reset state
    repeat (3) @(negedge rd_clk);
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_valid", 32'(m_valid), 32'd0);
    chk("rst_data", 32'(m_data), 32'd0);
    chk("rst_level", 32'(buf_level), 32'd0);
    rst_n = 1'b1;
    repeat (2) cycle(1'b1, 1'b0, 8'h00);

    // Test 1: five words, 4-cycle first-word latency, back-to-back delivery
    begin_test();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, 8'(8'h11 + i));
    repeat (12) cycle(1'b1, 1'b0, 8'h00);
    chk("t1_latency", 32'(first_valid - empty_fall), 32'd4);
    chk("t1_count", 32'(n_acc), 32'd5);
    chk("t1_consecutive", 32'(last_acc - first_acc), 32'd4);
    chk("t1_valid_low", 32'(m_valid), 32'd0);

    // Test 2: 64 streaming words, full throughput with level at most 1
    begin_test();
    for (int i = 0; i < 64; i++) cycle(1'b1, 1'b1, 8'(i));
    repeat (12) cycle(1'b1, 1'b0, 8'h00);
    chk("t2_count", 32'(n_acc), 32'd64);
    chk("t2_no_gaps", 32'(last_acc - first_acc), 32'd63);
    chk("t2_max_level", 32'(max_level <= 1), 32'd1);
    chk("t2_empty_sb", 32'(exp_q.size()), 32'd0);

    // Test 3: backpressure with 10 words queued
    begin_test();
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 8'(8'h40 + i));
    repeat (10) cycle(1'b0, 1'b0, 8'h00);
    chk("t3_level", 32'(buf_level), 32'd4);
    chk("t3_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("t3_head", 32'(m_data), 32'h40);
    chk("t3_valid", 32'(m_valid), 32'd1);
    rden_cnt = 0;
    repeat (6) cycle(1'b0, 1'b0, 8'h00);
    chk("t3_rd_en_held_low", 32'(rden_cnt), 32'd0);
    repeat (30) cycle(1'b1, 1'b0, 8'h00);
    chk("t3_count", 32'(n_acc), 32'd10);

    // Test 4: one word, three requests issued, two fail the fire check
    begin_test();
    cycle(1'b0, 1'b1, 8'h77);
    repeat (10) cycle(1'b0, 1'b0, 8'h00);
    chk("t4_requests", 32'(rden_cnt), 32'd3);
    chk("t4_level", 32'(buf_level), 32'd1);
    chk("t4_head", 32'(m_data), 32'h77);
    repeat (5) cycle(1'b1, 1'b0, 8'h00);
    chk("t4_count", 32'(n_acc), 32'd1);
    chk("t4_drained", 32'(buf_level), 32'd0);

    // Test 5: random writes against random m_ready, 1000 words
    begin_test();
    wr_cnt = 0;
    for (int i = 0; i < 20000 && wr_cnt < 1000; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        cycle(1'($urandom_range(0, 1)), 1'b1, 8'($urandom));
        wr_cnt++;
      end else begin
        cycle(1'($urandom_range(0, 1)), 1'b0, 8'h00);
      end
    end
    repeat (40) cycle(1'b1, 1'b0, 8'h00);
    chk("t5_count", 32'(n_acc), 32'd1000);
    chk("t5_empty_sb", 32'(exp_q.size()), 32'd0);

    // Test 6: reset with words buffered and in flight
    begin_test();
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'(i < 8), 8'(8'h60 + i));
      if (buf_level == 3'd3) break;
    end
    chk("t6_reach_l3", 32'(buf_level), 32'd3);
    wr_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("t6_rst_valid", 32'(m_valid), 32'd0);
    chk("t6_rst_data", 32'(m_data), 32'd0);
    chk("t6_rst_level", 32'(buf_level), 32'd0);
    exp_q.delete();
    stall_prev = 1'b0;
    repeat (2) @(negedge rd_clk);
    rst_n = 1'b1;
    begin_test();
    repeat (8) cycle(1'b1, 1'b0, 8'h00);
    chk("t6_no_stale", 32'(n_acc), 32'd0);
    cycle(1'b1, 1'b1, 8'hA5);
    repeat (10) cycle(1'b1, 1'b0, 8'h00);
    chk("t6_fresh_count", 32'(n_acc), 32'd1);
    chk("t6_empty_sb", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
